// File: rtl/fwd_hazard_pkg.sv
// Shared types and helpers for the forwarding/hazard controller.
// Optional MDU tracking is enabled with the FWD_HAZARD_MDU_EN macro.
package fwd_hazard_pkg;

    typedef enum logic [0:0] {
        MD_IDLE,
        MD_BUSY
    } md_state_t;

    // Select value meaning "take the operand from the register file"
    localparam int unsigned FWD_RF = 0;

    function automatic int unsigned sel_w_calc(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/md_busy_tracker.sv
// Busy tracker for the multi-cycle multiply/divide unit: once started it reports
// busy for exactly MD_LAT cycles and cannot be aborted except by reset.
module md_busy_tracker
    import fwd_hazard_pkg::*;
#(
    parameter int unsigned MD_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_acc,
    output logic busy
);

    localparam int unsigned CNT_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            MD_IDLE: begin
                if (start_acc) begin
                    state_d = MD_BUSY;
                    cnt_d   = CNT_W'(MD_LAT - 1);
                end
            end
            MD_BUSY: begin
                // Leave on the cycle the counter reads zero: MD_LAT busy cycles in total
                if (cnt_q == '0) begin
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    assign busy = (state_q == MD_BUSY);

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand bypass select and load-use / MDU stall generation from a shadow tag pipeline.
// Define FWD_HAZARD_MDU_EN to build the MDU busy tracker and its hazard term.
module fwd_hazard_unit
    import fwd_hazard_pkg::*;
#(
    parameter int unsigned REG_W      = 5,
    parameter int unsigned NSRC       = 2,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_STAGE = 2,
    parameter int unsigned MD_LAT     = 4,
    parameter int unsigned SEL_W      = sel_w_calc(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [NSRC*REG_W-1:0] id_src,
    input  logic [NSRC-1:0]       id_src_used,
    input  logic [REG_W-1:0]      id_rd,
    input  logic                  id_wr,
    input  logic                  id_load,
    input  logic                  id_md_start,
    input  logic                  id_md_use,
    input  logic                  flush,
    output logic                  stall,
    output logic [NSRC*SEL_W-1:0] fwd_sel,
    output logic                  md_busy
);

    // Stage k of the shadow pipeline lives at index k (1 = EX)
    logic [DEPTH:1]            tag_valid_q;
    logic [DEPTH:1]            tag_wr_q;
    logic [DEPTH:1]            tag_load_q;
    logic [DEPTH:1][REG_W-1:0] tag_rd_q;

    logic [NSRC-1:0] load_haz;
    logic            md_haz;
    logic            push;

    assign push = id_valid & ~stall & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_q <= '0;
            tag_wr_q    <= '0;
            tag_load_q  <= '0;
            tag_rd_q    <= '0;
        end else begin
            tag_valid_q[1] <= push;
            tag_wr_q[1]    <= push & id_wr;
            tag_load_q[1]  <= push & id_load;
            tag_rd_q[1]    <= id_rd;
            // Older stages drain regardless of stall
            for (int k = 2; k <= int'(DEPTH); k++) begin
                tag_valid_q[k] <= tag_valid_q[k-1];
                tag_wr_q[k]    <= tag_wr_q[k-1];
                tag_load_q[k]  <= tag_load_q[k-1];
                tag_rd_q[k]    <= tag_rd_q[k-1];
            end
        end
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        logic [REG_W-1:0] src;
        logic [DEPTH:1]   hit;
        logic [SEL_W-1:0] sel;
        logic             haz;

        assign src = id_src[i*REG_W +: REG_W];

        for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
            assign hit[k] = tag_valid_q[k] & tag_wr_q[k] & (tag_rd_q[k] == src)
                          & (src != '0) & id_src_used[i];
        end

        // Scan oldest to youngest so the youngest producer overrides
        always_comb begin
            sel = SEL_W'(FWD_RF);
            haz = 1'b0;
            for (int k = DEPTH; k >= 1; k--) begin
                if (hit[k]) begin
                    sel = SEL_W'(k);
                    haz = tag_load_q[k] & (k < int'(LOAD_STAGE));
                end
            end
        end

        assign fwd_sel[i*SEL_W +: SEL_W] = sel;
        assign load_haz[i]               = haz;
    end

`ifdef FWD_HAZARD_MDU_EN
    logic md_start_acc;

    assign md_start_acc = push & id_md_start;

    md_busy_tracker #(
        .MD_LAT (MD_LAT)
    ) u_md_busy_tracker (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_acc (md_start_acc),
        .busy      (md_busy)
    );

    assign md_haz = md_busy & id_valid & (id_md_use | id_md_start);
`else
    logic unused_md;

    assign unused_md = id_md_start ^ id_md_use;
    assign md_busy   = 1'b0;
    assign md_haz    = 1'b0;
`endif

    assign stall = id_valid & ~flush & ((|load_haz) | md_haz);

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: a default instance (LOAD_STAGE=2) and a
// LOAD_STAGE=3 instance share decode inputs; expectations are hand-computed.
module tb_fwd_hazard_unit;

`ifdef FWD_HAZARD_MDU_EN
    localparam logic MDU = 1'b1;
`else
    localparam logic MDU = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid, id_wr, id_load, id_md_start, id_md_use, flush;
    logic [9:0] id_src;
    logic [1:0] id_src_used;
    logic [4:0] id_rd;

    logic       stall_a, stall_b, busy_a, busy_b;
    logic [3:0] fwd_a, fwd_b;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_src      (id_src),
        .id_src_used (id_src_used),
        .id_rd       (id_rd),
        .id_wr       (id_wr),
        .id_load     (id_load),
        .id_md_start (id_md_start),
        .id_md_use   (id_md_use),
        .flush       (flush),
        .stall       (stall_a),
        .fwd_sel     (fwd_a),
        .md_busy     (busy_a)
    );

    fwd_hazard_unit #(
        .LOAD_STAGE (3)
    ) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_src      (id_src),
        .id_src_used (id_src_used),
        .id_rd       (id_rd),
        .id_wr       (id_wr),
        .id_load     (id_load),
        .id_md_start (id_md_start),
        .id_md_use   (id_md_use),
        .flush       (flush),
        .stall       (stall_b),
        .fwd_sel     (fwd_b),
        .md_busy     (busy_b)
    );

    typedef struct {
        logic       valid;
        logic [4:0] s0, s1;
        logic [1:0] used;
        logic [4:0] rd;
        logic       wr, load, fl;
        logic       e_stall;
        logic [1:0] e_f0, e_f1;
        logic       e3_stall;
        logic [1:0] e3_f0;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                                input logic [1:0] used, input logic [4:0] rd, input logic wr,
                                input logic ld, input logic fl, input logic es,
                                input logic [1:0] ef0, input logic [1:0] ef1,
                                input logic e3s, input logic [1:0] e3f0);
        vec_t r;
        r.valid = v; r.s0 = s0; r.s1 = s1; r.used = used; r.rd = rd;
        r.wr = wr; r.load = ld; r.fl = fl;
        r.e_stall = es; r.e_f0 = ef0; r.e_f1 = ef1; r.e3_stall = e3s; r.e3_f0 = e3f0;
        return r;
    endfunction

    function automatic vec_t bub();
        return mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic vec_t prod(input logic [4:0] rd);
        return mk(1, 0, 0, 2'b00, rd, 1, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] used, input logic [4:0] rd, input logic wr,
                         input logic ld, input logic fl, input logic mds, input logic mdu);
        id_valid = v; id_src = {s1, s0}; id_src_used = used; id_rd = rd;
        id_wr = wr; id_load = ld; flush = fl; id_md_start = mds; id_md_use = mdu;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);

        // Distance 1..4 forwarding from plain ALU producers of r3
        vecs.push_back(prod(3));
        vecs.push_back(mk(1, 3, 4, 2'b01, 8, 0, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(prod(3));
        vecs.push_back(bub());
        vecs.push_back(mk(1, 3, 4, 2'b01, 0, 0, 0, 0, 0, 2, 0, 0, 2));
        vecs.push_back(prod(3));
        vecs.push_back(bub());
        vecs.push_back(bub());
        vecs.push_back(mk(1, 3, 3, 2'b11, 0, 0, 0, 0, 0, 3, 3, 0, 3));
        vecs.push_back(prod(3));
        vecs.push_back(bub());
        vecs.push_back(bub());
        vecs.push_back(bub());
        vecs.push_back(mk(1, 3, 3, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // lw r5 then add r5 held in decode: A stalls 1 cycle, B stalls 2
        vecs.push_back(mk(1, 0, 0, 2'b00, 5, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 5, 0, 2'b01, 9, 1, 0, 0, 1, 1, 0, 1, 1));
        vecs.push_back(mk(1, 5, 0, 2'b01, 9, 1, 0, 0, 0, 2, 0, 1, 2));
        vecs.push_back(mk(1, 5, 0, 2'b01, 9, 1, 0, 0, 0, 3, 0, 0, 3));
        vecs.push_back(bub());
        vecs.push_back(bub());
        vecs.push_back(bub());
        // Two producers of r7: youngest wins; r0 never forwards
        vecs.push_back(prod(7));
        vecs.push_back(prod(7));
        vecs.push_back(mk(1, 7, 0, 2'b01, 0, 0, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(prod(0));
        vecs.push_back(mk(1, 0, 7, 2'b11, 0, 0, 0, 0, 0, 0, 3, 0, 0));
        vecs.push_back(bub());
        vecs.push_back(bub());
        vecs.push_back(bub());
        // Load hazard under flush: no stall, squashed lw r9 never forwards
        vecs.push_back(mk(1, 0, 0, 2'b00, 5, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 5, 0, 2'b01, 9, 1, 1, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 9, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 3, 0, 0, 3));

        repeat (2) @(posedge clk);
        #2;
        chk("reset md_busy", {31'd0, busy_a}, 0);
        chk("reset stall", {31'd0, stall_a}, 0);
        chk("reset fwd_sel", {28'd0, fwd_a}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        chk("post-reset stall", {31'd0, stall_a}, 0);
        chk("post-reset fwd_sel b", {28'd0, fwd_b}, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            drive(v.valid, v.s0, v.s1, v.used, v.rd, v.wr, v.load, v.fl, 0, 0);
            #2;
            chk($sformatf("vec%0d stall", i), {31'd0, stall_a}, {31'd0, v.e_stall});
            chk($sformatf("vec%0d fwd0", i), {30'd0, fwd_a[1:0]}, {30'd0, v.e_f0});
            chk($sformatf("vec%0d fwd1", i), {30'd0, fwd_a[3:2]}, {30'd0, v.e_f1});
            chk($sformatf("vec%0d md_busy", i), {31'd0, busy_a}, 0);
            chk($sformatf("vec%0d ls3 stall", i), {31'd0, stall_b}, {31'd0, v.e3_stall});
            chk($sformatf("vec%0d ls3 fwd0", i), {30'd0, fwd_b[1:0]}, {30'd0, v.e3_f0});
            next_cycle();
        end

        // MDU: start at t, mfhi held t+1..t+5
        drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
        #2;
        chk("md start stall", {31'd0, stall_a}, 0);
        chk("md start busy", {31'd0, busy_a}, 0);
        next_cycle();
        for (int j = 1; j <= 4; j++) begin
            drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
            #2;
            chk($sformatf("md t+%0d busy", j), {31'd0, busy_a}, {31'd0, MDU});
            chk($sformatf("md t+%0d stall", j), {31'd0, stall_a}, {31'd0, MDU});
            next_cycle();
        end
        drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
        #2;
        chk("md t+5 busy", {31'd0, busy_a}, 0);
        chk("md t+5 stall", {31'd0, stall_a}, 0);
        next_cycle();
        // Second start while busy stalls like a user
        drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
        #2;
        chk("md restart stall", {31'd0, stall_a}, 0);
        next_cycle();
        drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
        #2;
        chk("md start-while-busy stall", {31'd0, stall_a}, {31'd0, MDU});
        next_cycle();
        drive(1, 0, 0, 2'b00, 11, 1, 0, 0, 0, 0);
        #2;
        chk("r11 producer stall", {31'd0, stall_a}, 0);
        next_cycle();

        // Asynchronous reset while busy and with valid stages
        drive(1, 11, 0, 2'b01, 0, 0, 0, 0, 0, 0);
        #2;
        chk("pre-reset fwd0", {30'd0, fwd_a[1:0]}, 1);
        chk("pre-reset busy", {31'd0, busy_a}, {31'd0, MDU});
        rst_n = 1'b0;
        #1;
        chk("in-reset busy", {31'd0, busy_a}, 0);
        chk("in-reset fwd0", {30'd0, fwd_a[1:0]}, 0);
        chk("in-reset ls3 fwd0", {30'd0, fwd_b[1:0]}, 0);
        chk("in-reset stall", {31'd0, stall_a}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        drive(1, 11, 0, 2'b01, 0, 0, 0, 0, 0, 1);
        #2;
        chk("after-reset fwd0", {30'd0, fwd_a[1:0]}, 0);
        chk("after-reset stall", {31'd0, stall_a}, 0);
        chk("after-reset busy", {31'd0, busy_a}, 0);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
